// File: rtl/frontend_inst_queue_pkg.sv
// Shared helpers for the frontend instruction queue.
// The package stays free of data typedefs. The package layout (pc, inst,
// predict, excp) belongs to the instantiator and arrives only as DATA_WIDTH.
package frontend_inst_queue_pkg;

    // Ceiling log2 for sizing pointers and row addresses from depths.
    // It returns 0 for a value of 1.
    function automatic int iq_clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/frontend_inst_queue_bank.sv
// One interleaved bank of the instruction queue. The bank holds the even
// slots or the odd slots of the queue.
// Ports:
//   clk    - clock
//   we     - write enable, captured on the rising edge of clk
//   waddr  - row to write
//   wdata  - package to store
//   raddr  - row to read, asynchronous
//   rdata  - contents of row raddr
// The storage is not reset. Readers use the valid bits from the top level
// to tell whether a row holds a package.
module iq_bank
    import frontend_inst_queue_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int BANK_DEPTH = 8,
    localparam int ROW_W     = iq_clog2(BANK_DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ROW_W-1:0]      waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ROW_W-1:0]      raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [BANK_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/frontend_inst_queue.sv
// Decoupling queue between ifetch and decode. Each cycle the queue can take
// in 0-2 packages and can give out 0-2 packages. The storage is split into
// an even bank and an odd bank, so any two consecutive slots fall in
// different banks. Each bank therefore sees at most one write and one read
// per cycle.
// Ports:
//   clk, rst_n     - clock, synchronous active-low reset
//   flush_i        - drop all contents. It overrides any read or write in the
//                    same cycle.
//   write_valid_i  - write request
//   write_ready_o  - at least two free entries. It depends only on the
//                    registered count.
//   write_num_i    - number of packages to append (0..2)
//   write_data_i   - [0] older package, [1] younger package
//   read_valid_o   - [i] set when entry head+i is present
//   read_ready_i   - read request
//   read_num_i     - number of packages consumed (0..2)
//   read_data_o    - [0] head, [1] head+1. Combinational from storage.
module frontend_inst_queue
    import frontend_inst_queue_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 16,
    localparam int BANK_DEPTH = DEPTH / 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       write_valid_i,
    output logic                       write_ready_o,
    input  logic [1:0]                 write_num_i,
    input  logic [1:0][DATA_WIDTH-1:0] write_data_i,
    output logic [1:0]                 read_valid_o,
    input  logic                       read_ready_i,
    input  logic [1:0]                 read_num_i,
    output logic [1:0][DATA_WIDTH-1:0] read_data_o
);

    localparam int PTR_W = iq_clog2(DEPTH);
    localparam int ROW_W = PTR_W - 1;
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             write_fire;
    logic [1:0]       wr_num_eff;
    logic [1:0]       rd_num_eff;

    logic [1:0]                 bank_we;
    logic [1:0][ROW_W-1:0]      bank_waddr;
    logic [1:0][ROW_W-1:0]      bank_raddr;
    logic [1:0][DATA_WIDTH-1:0] bank_wdata;
    logic [1:0][DATA_WIDTH-1:0] bank_rdata;
    logic [ROW_W-1:0]           wr_row;
    logic [ROW_W-1:0]           rd_row;

    assign write_ready_o = (count <= CNT_W'(DEPTH - 2));
    assign write_fire    = write_valid_i & write_ready_o;
    assign wr_num_eff    = write_fire   ? write_num_i : 2'd0;
    assign rd_num_eff    = read_ready_i ? read_num_i  : 2'd0;
    assign count_next    = count + CNT_W'(wr_num_eff) - CNT_W'(rd_num_eff);

    assign read_valid_o  = {count >= CNT_W'(2), count != '0};

    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(wr_num_eff);
            rd_ptr <= rd_ptr + PTR_W'(rd_num_eff);
            count  <= count_next;
        end
    end

    assign wr_row = wr_ptr[PTR_W-1:1];
    assign rd_row = rd_ptr[PTR_W-1:1];

    // Bank steering. When a pointer is odd, the slot after it is in the even
    // bank on the next row. The row add wraps modulo BANK_DEPTH, so a pair
    // that spans slot DEPTH-1 and slot 0 maps to row 0 of bank 0. The odd bank
    // always uses the pointer's own row.
    always_comb begin
        bank_waddr[1] = wr_row;
        bank_waddr[0] = wr_ptr[0] ? wr_row + ROW_W'(1) : wr_row;
        if (!wr_ptr[0]) begin
            bank_we    = {wr_num_eff == 2'd2, wr_num_eff != 2'd0};
            bank_wdata = {write_data_i[1], write_data_i[0]};
        end else begin
            bank_we    = {wr_num_eff != 2'd0, wr_num_eff == 2'd2};
            bank_wdata = {write_data_i[0], write_data_i[1]};
        end

        bank_raddr[1] = rd_row;
        bank_raddr[0] = rd_ptr[0] ? rd_row + ROW_W'(1) : rd_row;
        if (!rd_ptr[0]) begin
            read_data_o = bank_rdata;
        end else begin
            read_data_o = {bank_rdata[0], bank_rdata[1]};
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        iq_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .BANK_DEPTH (BANK_DEPTH)
        ) u_bank (
            .clk   (clk),
            .we    (bank_we[b]),
            .waddr (bank_waddr[b]),
            .wdata (bank_wdata[b]),
            .raddr (bank_raddr[b]),
            .rdata (bank_rdata[b])
        );
    end

    a_write_num_legal : assert property (@(posedge clk) disable iff (!rst_n)
        !(write_valid_i && write_num_i == 2'd3));
    a_read_within_count : assert property (@(posedge clk) disable iff (!rst_n)
        !(read_ready_i && (CNT_W'(read_num_i) > count)));
    a_write_within_free : assert property (@(posedge clk) disable iff (!rst_n)
        !(write_fire && (CNT_W'(write_num_i) > (CNT_W'(DEPTH) - count))));

endmodule

// File: doc/frontend_inst_queue.md
Name: frontend_inst_queue

Overview:
- Decoupling instruction queue between the ifetch stage and the decoder/issue buffer in the core frontend.
- Accepts 0–2 fetched instruction packages per cycle and presents the oldest 0–2 packages to decode.
- Consumption is partial, 0–2 per cycle, set by the issue logic.
- Storage is split into two interleaved banks, so each bank sees at most one write and one read per cycle.
- Whole-queue flush on redirect.

Parameters:
- DATA_WIDTH, 64, width of one package (pc + inst + predict + excp), set by the instantiator.
- DEPTH, 16, total entries. Power of two, >= 4.
- BANK_DEPTH, DEPTH/2, entries per bank. Derived; do not override.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- flush_i  in  1  discard all contents (frontend redirect)
- write_valid_i  in  1  write request qualifier
- write_ready_o  out  1  at least 2 free entries
- write_num_i  in  2  packages to append this cycle (0..2)
- write_data_i  in  2xDATA_WIDTH  [0] older, [1] younger
- read_valid_o  out  2  [i] = entry i from head is present
- read_ready_i  in  1  read request qualifier
- read_num_i  in  2  packages consumed this cycle (0..2)
- read_data_o  out  2xDATA_WIDTH  [0] = head, [1] = head+1

Behaviour:
- Reset: rst_n is synchronous, active-low, on clk.
  - Reset clears wr_ptr, rd_ptr and count to 0.
  - After reset: read_valid_o = 2'b00, write_ready_o = 1.
  - Storage contents are not reset.
- State:
  - wr_ptr, rd_ptr: log2(DEPTH) bits, wrap modulo DEPTH.
  - count: log2(DEPTH)+1 bits.
  - Bank select = ptr[0]; bank row = ptr >> 1.
- write_ready_o = (DEPTH - count) >= 2. Registered-count only; independent of the same-cycle read, so there is no comb path from read_num_i.
- Write fire = write_valid_i & write_ready_o. On fire:
  - write_data_i[k] goes to slot wr_ptr+k for k < write_num_i.
  - wr_ptr advances by write_num_i.
  - write_num_i = 0 is a legal no-op.
- read_valid_o[0] = count >= 1; read_valid_o[1] = count >= 2.
- read_data_o is combinational from storage:
  - [0] from bank rd_ptr[0], [1] from the other bank.
  - Rows are chosen so [1] is slot rd_ptr+1, including wrap from DEPTH-1 to 0.
  - Value is don't-care where read_valid_o = 0.
- Read fire = read_ready_i. rd_ptr advances by read_num_i.
- count_next = count + (write fire ? write_num_i : 0) - (read fire ? read_num_i : 0).
- Latency: a package written in cycle t is visible on read_data_o in cycle t+1. No same-cycle bypass.
- Simultaneous read and write are allowed in any combination. Full-with-read does not enable a write in the same cycle.
- Flush:
  - flush_i has priority over read and write in the same cycle.
  - Next cycle: pointers = 0, count = 0, read_valid_o = 0.
  - Writes and reads in the flush cycle are discarded.
- Reset asserted mid-operation behaves as flush plus reset.
- Illegal stimulus (simulation assertions; RTL behaviour unspecified):
  - write_num_i == 3.
  - read_num_i > count while read_ready_i.
  - Write fire with write_num_i > free entries. Unreachable, given ready >= 2.
- Wrap-around: a 2-wide write or read that straddles slot DEPTH-1 to 0 stays correct. Bank interleave guarantees no port conflict.

Decomposition:
- No new package typedefs. The package struct comes from the instantiator via DATA_WIDTH.
- Shared package holds only a clog2 helper, if not already present.
- One sub-module, iq_bank:
  - BANK_DEPTH x DATA_WIDTH register array.
  - 1 sync write port (we, waddr, wdata) and 1 async read port (raddr, rdata).
  - Instantiated twice.
  - Top-level handles bank steering and the data swap on rd_ptr[0] / wr_ptr[0].
- Estimated top + bank RTL: ~150–220 lines.

Test Plan:
- Reset then idle:
  - Stimulus: hold rst_n = 0 for 2 cycles, release, then no stimulus.
  - Required: read_valid_o = 00 and write_ready_o = 1 on every cycle.
- Odd-aligned 2-wide write:
  - Stimulus: write num=1 {A}, next cycle num=2 {B,C}, no reads.
  - Required: cycle+1 read_valid=01, data[0]=A. Cycle+2 read_valid=11, data={A,B}.
  - Then read_num=1 gives {B,C}; read_num=2 gives valid=00.
- Fill to full (DEPTH=16):
  - Stimulus: 8 writes of num=2.
  - Required: write_ready_o drops to 0 at count=16.
  - Required: write_ready_o also drops to 0 at count=15 after a 1+2*7 pattern.
  - Required: a write attempted while not ready is dropped (count unchanged).
- Concurrent read/write at steady state with wrap:
  - Stimulus: write num=2 and read num=2 every cycle for 40 cycles, sequential tags 0..79.
  - Required: read order exactly 0,1,2,… across pointer wrap; count constant.
- Flush priority:
  - Stimulus: count=5, assert flush_i together with write num=2 and read num=1.
  - Required: next cycle read_valid=00 and write_ready=1.
  - Required: the following write {X} appears as head with no stale data.
- Mixed random:
  - Stimulus: 10k cycles of random legal write_num/read_num/flush.
  - Required: matches a reference queue model; no assertion fires.
